// File: rtl/pulse_sync_scheduler.sv
// Round-robin scheduler that funnels per-requester event pulses into one
// spaced pulse stream for a shared toggle synchronizer. Optional overflow: PULSE_SCHED_OVF_EN.
module pulse_sync_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_pulse,
    output logic                       pulse_out,
    output logic [$clog2(NUM_REQ)-1:0] pulse_id,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         pending,
    input  logic [NUM_REQ-1:0]         ovf_clr,
    output logic [NUM_REQ-1:0]         ovf
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int IW1 = IDW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       gnt_id_q, gnt_id_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [NUM_REQ-1:0]   gnt_vec;
    logic                 found;
    logic [IDW-1:0]       sel;

    // First pending requester at or after the pointer, wrapping around.
    always_comb begin
        logic [IDW:0] sum;
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + IW1'(k);
            if (sum >= IW1'(NUM_REQ)) begin
                sum = sum - IW1'(NUM_REQ);
            end
            if (!found && pending_q[sum[IDW-1:0]]) begin
                found = 1'b1;
                sel   = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        gnt_vec  = '0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_vec[sel] = 1'b1;
                    gnt_id_d     = sel;
                    ptr_d        = (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + IDW'(1);
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = 8'(GAP_CYCLES);
                state_d = ST_GAP;
            end
            ST_GAP: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        // A fresh pulse on the grant cycle re-arms the flag instead of being lost.
        pending_d = (pending_q & ~gnt_vec) | req_pulse;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            gnt_id_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_id_q  <= gnt_id_d;
            pending_q <= pending_d;
        end
    end

    assign pulse_out = (state_q == ST_ISSUE);
    assign pulse_id  = pulse_out ? gnt_id_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign pending   = pending_q;

`ifdef PULSE_SCHED_OVF_EN
    logic [NUM_REQ-1:0] ovf_q, ovf_d;

    // Set beats clear so an event lost in the clearing cycle stays visible.
    always_comb begin
        ovf_d = (ovf_q & ~ovf_clr) | (req_pulse & pending_q & ~gnt_vec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ^ovf_clr;
    assign ovf            = '0;
`endif

endmodule

// File: doc/pulse_sync_scheduler.md
PULSE_SYNC_SCHEDULER -- requirements
Module: pulse_sync_scheduler

Interface
REQ-001 The block SHALL use a single clock; reset SHALL be asynchronous and active-high (`clk`, `rst`).
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal range 2..16).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 3, giving the minimum idle cycles between issued pulses (legal range 1..255; set to toggle-sync SYNC_DEPTH+1).
REQ-004 The block SHALL have the following ports, one per line:
- clk  input  1  clock.
- rst  input  1  async active-high reset.
- req_pulse  input  NUM_REQ  one-cycle event pulse per requester.
- pulse_out  output  1  one-cycle pulse driving the shared toggle-synchronizer `in`.
- pulse_id  output  $clog2(NUM_REQ)  index of the requester served; valid only while pulse_out=1.
- busy  output  1  high in ISSUE or GAP.
- pending  output  NUM_REQ  registered per-requester pending flags.
- ovf_clr  input  NUM_REQ  clears sticky overflow flags.
- ovf  output  NUM_REQ  sticky per-requester lost-event flags.

Function
REQ-005 The block SHALL set pending[i] on the clock edge after req_pulse[i]=1.
REQ-006 The block SHALL clear pending[i] on the edge on which requester i is granted.
REQ-007 If req_pulse[i]=1 in the same cycle requester i is granted, pending[i] SHALL remain 1 (new event retained).
REQ-008 The FSM SHALL have three states: IDLE, ISSUE, GAP.
- IDLE: if any pending bit is set, grant one requester and go to ISSUE; otherwise stay in IDLE.
- ISSUE: pulse_out=1 for exactly one cycle, pulse_id=granted index; gap counter loads GAP_CYCLES; go to GAP.
- GAP: decrement counter each cycle; go to IDLE on the cycle counter reaches 1.
REQ-009 Latency: req_pulse in cycle t SHALL give pending=1 in t+1 and pulse_out=1 in t+2 when the FSM is IDLE with no competing requests.
REQ-010 Consecutive pulse_out assertions SHALL be spaced exactly GAP_CYCLES+2 cycles apart when requests are continuously pending.
REQ-011 Arbitration SHALL be round-robin:
- the search starts at the pointer, which resets to 0;
- after granting i, the pointer becomes (i+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-012 pulse_id SHALL hold 0 whenever pulse_out=0.
REQ-013 A grant SHALL be decided only in IDLE; pending bits set during ISSUE or GAP SHALL wait for the next IDLE.
REQ-014 busy SHALL equal (state != IDLE).

Reset
REQ-015 On rst=1 the block SHALL asynchronously force: state=IDLE, gap counter=0, pointer=0, pending=0, ovf=0, pulse_out=0, pulse_id=0.
REQ-016 Reset asserted during ISSUE or GAP SHALL abort the operation with no further pulse_out; all queued pending events SHALL be discarded.
REQ-017 The first grant after reset deassertion SHALL follow REQ-009 timing.

Configuration
REQ-018 Macro PULSE_SCHED_OVF_EN SHALL control overflow detection.
REQ-019 With PULSE_SCHED_OVF_EN defined, ovf[i] SHALL set when req_pulse[i]=1 while pending[i]=1 and requester i is not granted that cycle.
REQ-020 With PULSE_SCHED_OVF_EN defined, ovf[i] SHALL clear when ovf_clr[i]=1; a simultaneous set SHALL win.
REQ-021 Without PULSE_SCHED_OVF_EN, ovf SHALL be constant 0, ovf_clr SHALL be ignored, and no overflow logic SHALL be synthesized; all other behaviour SHALL be unchanged.

Verification
REQ-022 Single request (NUM_REQ=4, GAP_CYCLES=3): req_pulse=4'b0100 at cycle 10 -> pending[2]=1 at 11, pulse_out=1 and pulse_id=2 at 12, busy high at cycles 12-15, IDLE at 16.
REQ-023 Simultaneous requests: req_pulse=4'b1111 at cycle 0 from reset -> pulse_out at cycles 2, 7, 12, 17 with pulse_id 0, 1, 2, 3.
REQ-024 Pointer wrap: grant 3, then req_pulse=4'b1001 at cycle 0 -> next pulse_id=0, then pulse_id=3 five cycles later.
REQ-025 Re-request on grant cycle: req_pulse[1]=1 in the IDLE grant cycle for requester 1 -> pending[1] stays 1, second pulse_id=1 exactly 5 cycles after the first, ovf[1]=0.
REQ-026 Overflow (macro defined): req_pulse[0] pulsed at cycles 0 and 4 while pulse_out serves another requester -> ovf[0]=1 at cycle 5, only one id-0 pulse issued; ovf_clr[0]=1 -> ovf[0]=0 next cycle; with the macro undefined, ovf stays 0.
REQ-027 Reset mid-GAP: rst asserted 2 cycles after pulse_out with pending=4'b0011 -> pending=0, busy=0 immediately; no pulse_out until a new req_pulse arrives.
